// File: rtl/seq_det_pkg.sv
// Shared definitions for the sequence-detector sequencer: state codes, defaults, saturating add.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_det_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_CLR   = 3'd1;
    localparam state_t ST_SHIFT = 3'd2;
    localparam state_t ST_DRAIN = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    localparam int SIZE_DEF    = 64;
    localparam int RST_CYC_DEF = 2;
    localparam int CNT_W_DEF   = 7;

    // Increment that sticks at max_val instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-load shift register emitting LSB-first, with a count of shifts since load.
// Latency: bit 0 available the cycle after load; each shift exposes the next bit one cycle later.
// Backpressure: none; shifts only when told to, holds otherwise.
module bit_serializer
    import seq_det_pkg::*;
#(
    parameter  int SIZE = SIZE_DEF,
    localparam int BC_W = $clog2(SIZE + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            shift,
    input  logic [SIZE-1:0] data_in,
    output logic            ser_bit,
    output logic [BC_W-1:0] bit_cnt
);

    logic [SIZE-1:0] shreg_q, shreg_d;
    logic [BC_W-1:0] bit_cnt_q, bit_cnt_d;

    // Load wins over shift; zeros fill in from the top so the tail reads as 0.
    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        if (load) begin
            shreg_d   = data_in;
            bit_cnt_d = '0;
        end else if (shift) begin
            shreg_d   = {1'b0, shreg_q[SIZE-1:1]};
            bit_cnt_d = bit_cnt_q + BC_W'(1);
        end
    end

    // Register and shift counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign ser_bit = shreg_q[0];
    assign bit_cnt = bit_cnt_q;

endmodule

// File: rtl/seq_det_ctrl.sv
// Drives a Mealy/Moore detector pair: reset pulse, LSB-first serial word, saturating flag counts.
// Latency: done pulses RST_CYC+SIZE+1 cycles after the accepted start edge.
// Backpressure: start is only honoured in IDLE; requests while busy or done are dropped.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int SIZE    = SIZE_DEF,
    parameter int RST_CYC = RST_CYC_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SIZE-1:0]  data_in,
    input  logic             mealy_flag,
    input  logic             moore_flag,
    output logic             det_din,
    output logic             det_rst,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] mealy_cnt,
    output logic [CNT_W-1:0] moore_cnt
);

    localparam int          BC_W    = $clog2(SIZE + 1);
    localparam int          RC_W    = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    state_t           state_q, state_d;
    logic [RC_W-1:0]  rc_q, rc_d;
    logic [CNT_W-1:0] mealy_cnt_q, mealy_cnt_d;
    logic [CNT_W-1:0] moore_cnt_q, moore_cnt_d;
    logic             det_din_q, det_din_d;
    logic             det_rst_q, det_rst_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             ser_load, ser_shift, ser_bit;
    logic [BC_W-1:0]  bit_cnt;
    logic             clr_last, shift_first, shift_last;

    bit_serializer #(.SIZE(SIZE)) u_ser (
        .clk     (clk),
        .rst     (rst),
        .load    (ser_load),
        .shift   (ser_shift),
        .data_in (data_in),
        .ser_bit (ser_bit),
        .bit_cnt (bit_cnt)
    );

    // The serializer shifts once on the last CLR edge, so during SHIFT cycle i it has shifted i+1 times.
    assign clr_last    = (rc_q == RC_W'(RST_CYC - 1));
    assign shift_first = (bit_cnt == BC_W'(1));
    assign shift_last  = (bit_cnt == BC_W'(SIZE));

    // All state and registered outputs; det_rst comes out of reset asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rc_q        <= '0;
            mealy_cnt_q <= '0;
            moore_cnt_q <= '0;
            det_din_q   <= 1'b0;
            det_rst_q   <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rc_q        <= rc_d;
            mealy_cnt_q <= mealy_cnt_d;
            moore_cnt_q <= moore_cnt_d;
            det_din_q   <= det_din_d;
            det_rst_q   <= det_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next state plus serializer control.
    always_comb begin
        state_d   = state_q;
        rc_d      = rc_q;
        ser_load  = 1'b0;
        ser_shift = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_CLR;
                    rc_d     = '0;
                    ser_load = 1'b1;
                end
            end
            ST_CLR: begin
                if (clr_last) begin
                    state_d   = ST_SHIFT;
                    ser_shift = 1'b1;
                end else begin
                    rc_d = rc_q + RC_W'(1);
                end
            end
            ST_SHIFT: begin
                if (shift_last) begin
                    state_d = ST_DRAIN;
                end else begin
                    ser_shift = 1'b1;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_comb begin
        det_din_d = (state_d == ST_SHIFT) ? ser_bit : 1'b0;
        det_rst_d = (state_d == ST_CLR);
        busy_d    = (state_d == ST_CLR) || (state_d == ST_SHIFT) || (state_d == ST_DRAIN);
        done_d    = (state_d == ST_DONE);
    end

    // Flag counters: Mealy on every SHIFT edge, Moore one edge later (skip SHIFT edge 0, add DRAIN).
    always_comb begin
        mealy_cnt_d = mealy_cnt_q;
        moore_cnt_d = moore_cnt_q;
        if (state_q == ST_IDLE && start) begin
            mealy_cnt_d = '0;
            moore_cnt_d = '0;
        end else if (state_q == ST_SHIFT) begin
            if (mealy_flag)
                mealy_cnt_d = CNT_W'(sat_inc(32'(mealy_cnt_q), CNT_MAX));
            if (moore_flag && !shift_first)
                moore_cnt_d = CNT_W'(sat_inc(32'(moore_cnt_q), CNT_MAX));
        end else if (state_q == ST_DRAIN) begin
            if (moore_flag)
                moore_cnt_d = CNT_W'(sat_inc(32'(moore_cnt_q), CNT_MAX));
        end
    end

    assign det_din   = det_din_q;
    assign det_rst   = det_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign mealy_cnt = mealy_cnt_q;
    assign moore_cnt = moore_cnt_q;

endmodule
